sram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that acts as the initiator on the 64x8 dual-port SRAM port set: data, write_addr, we, read_addr, q.
- The SRAM itself is external and has a registered read: q updates one edge after read_addr is sampled.
- The block owns the pointers, occupancy and flags, and presents a push/pop interface to the client logic.
- Both SRAM clocks are tied to this block's clock at the parent level.

---
 rtl/sram_fifo_ctrl.sv | 83 ++++++++
 tb/tb_sram_fifo_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving an external 64x8 dual-port SRAM with registered read.
// Owns pointers, occupancy and flags; pop data arrives one cycle after the pop.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ONE_P   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_pop_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push_acc;
    logic w_pop_acc;

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign w_push_acc = push & ~w_full;
    assign w_pop_acc  = pop & ~w_empty;

    // The SRAM write port must stay quiet while held in reset.
    assign ram_we         = w_push_acc & reset_n;
    assign ram_data       = push_data;
    assign ram_write_addr = r_wr_ptr;
    assign ram_read_addr  = r_rd_ptr;

    assign pop_data  = ram_q;
    assign pop_valid = r_pop_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + ONE_P;
            if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + ONE_P;
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
            r_pop_valid <= w_pop_acc;
            r_overflow  <= push & w_full;
            r_underflow <= pop & w_empty;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural SRAM and a pop-data scoreboard.
// Stimulus queues expected pop words; a negedge monitor compares them.
module tb_sram_fifo_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = '0;
    logic       pop = 1'b0;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic [6:0] count;
    logic       overflow;
    logic       underflow;
    logic [7:0] ram_data;
    logic [5:0] ram_write_addr;
    logic       ram_we;
    logic [5:0] ram_read_addr;
    logic [7:0] ram_q = '0;

    logic [7:0] mem [64];
    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    sram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clock(clock), .reset_n(reset_n),
        .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow),
        .ram_data(ram_data), .ram_write_addr(ram_write_addr),
        .ram_we(ram_we), .ram_read_addr(ram_read_addr),
        .ram_q(ram_q)
    );

    // External SRAM: write on we, registered read every edge.
    always @(posedge clock) begin
        if (ram_we) mem[ram_write_addr] <= ram_data;
        ram_q <= mem[ram_read_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (reset_n && pop_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pop_valid: got data %0h expected none",
                         pop_data);
            end else begin
                chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Inputs change at posedge+1; returns at the following posedge+1.
    task automatic step(input logic p, input logic [7:0] d, input logic q);
        push = p;
        push_data = d;
        pop = q;
        @(posedge clock);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic pop_exp(input logic [7:0] d);
        exp_q.push_back(d);
        step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        // Reset state, including forced ram_we with push requested
        #2;
        push = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        push = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Basic push/pop
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk("basic_count3", 32'(count), 32'd3);
        pop_exp(8'h11);
        pop_exp(8'h22);
        pop_exp(8'h33);
        chk("basic_count0", 32'(count), 32'd0);
        chk("basic_empty", 32'(empty), 32'd1);
        step(1'b0, 8'h00, 1'b0);

        // Fill to full, overflow, drain
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd64);
        push = 1'b1;
        push_data = 8'hAA;
        #1;
        chk("ovf_ram_we", 32'(ram_we), 32'd0);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd64);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 64; i++) pop_exp(8'(i));
        chk("drain_empty", 32'(empty), 32'd1);

        // Wrap: 60 in/out, then overlapped push/pop across the wrap
        for (int i = 0; i < 60; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        chk("wrap_count60", 32'(count), 32'd60);
        for (int i = 0; i < 60; i++) pop_exp(8'(8'h80 + i));
        step(1'b1, 8'hC0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            exp_q.push_back(8'(8'hC0 + i - 1));
            step(1'b1, 8'(8'hC0 + i), 1'b1);
        end
        chk("wrap_both_count", 32'(count), 32'd1);
        pop_exp(8'hC9);
        chk("wrap_count0", 32'(count), 32'd0);

        // Push+pop while empty
        step(1'b1, 8'h5A, 1'b1);
        chk("udf_pulse", 32'(underflow), 32'd1);
        chk("udf_count", 32'(count), 32'd1);
        pop_exp(8'h5A);
        chk("udf_clear", 32'(underflow), 32'd0);
        chk("udf_count0", 32'(count), 32'd0);

        // Push+pop while full
        for (int i = 0; i < 64; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        chk("full2", 32'(full), 32'd1);
        exp_q.push_back(8'h40);
        step(1'b1, 8'h77, 1'b1);
        chk("fullpp_ovf", 32'(overflow), 32'd1);
        chk("fullpp_count", 32'(count), 32'd63);
        for (int i = 1; i < 64; i++) pop_exp(8'(8'h40 + i));
        chk("fullpp_empty", 32'(empty), 32'd1);

        // Reset during an in-flight pop
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("inflight_valid", 32'(pop_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_pop_valid", 32'(pop_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        push = 1'b1;
        push_data = 8'h99;
        #1;
        chk("arst_ram_we", 32'(ram_we), 32'd0);
        @(posedge clock);
        #1;
        chk("arst_ram_we2", 32'(ram_we), 32'd0);
        chk("arst_count2", 32'(count), 32'd0);
        push = 1'b0;
        reset_n = 1'b1;
        step(1'b1, 8'h99, 1'b0);
        chk("post_count", 32'(count), 32'd1);
        pop_exp(8'h99);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_empty", 32'(empty), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
